// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Fetch-to-decode handshake plus the execute-stage redirect path.
//
//   Signals:
//     redirect_valid / redirect_target : execute asks fetch to restart at target
//     fetch_valid / fetch_ready        : instruction handshake toward decode
//     fetch_instr                      : 32-bit instruction word
//     fetch_pc / fetch_pc_plus4        : byte address of fetch_instr and +4
//     fetch_pred_taken                 : fetch steered away from pc+4 after it
//
//   Modports:
//     master : the fetch unit (drives the instruction side)
//     slave  : decode / execute (drives ready and redirect)
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [31:0]     fetch_instr;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_plus4;
    logic            fetch_pred_taken;

    modport master (
        input  redirect_valid, redirect_target, fetch_ready,
        output fetch_valid, fetch_instr, fetch_pc, fetch_pc_plus4, fetch_pred_taken
    );

    modport slave (
        output redirect_valid, redirect_target, fetch_ready,
        input  fetch_valid, fetch_instr, fetch_pc, fetch_pc_plus4, fetch_pred_taken
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Holds the PC and the program memory and hands one instruction per cycle
//   to decode. JAL targets are resolved here from the J-type immediate;
//   execute can redirect fetch at any time. Misaligned or out-of-range
//   fetch addresses put the unit into a sticky FAULT state left only by reset.
//
//   Optional build macro:
//     FETCH_BRANCH_PREDICT_EN : predict backward B-type branches taken
//                               (static BTFN); forward branches fall through.
//
//   Ports:
//     clk, reset           : clock (rising edge), async active-high reset
//     prog_we/addr/wdata   : program memory write port (word indexed)
//     fif (master)         : redirect input and decode handshake
//     fault, fault_addr    : sticky fault flag and the offending address
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter int              PROG_WORDS   = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_WORDS)-1:0] prog_addr,
    input  logic [31:0]                   prog_wdata,
    fetch_unit_if.master                  fif,
    output logic                          fault,
    output logic [XLEN-1:0]               fault_addr
);
    localparam int              AW        = $clog2(PROG_WORDS);
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(PROG_WORDS) << 2;
    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);
    localparam logic [6:0]      OP_JAL    = 7'b1101111;
`ifdef FETCH_BRANCH_PREDICT_EN
    localparam logic [6:0]      OP_BRANCH = 7'b1100011;
`endif

    typedef enum logic {RUN, FAULT} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc;
    logic [31:0]     mem [PROG_WORDS];
    logic [31:0]     instr;
    logic [XLEN-1:0] jal_off;
    logic [XLEN-1:0] next_pc;
    logic            pred_nx;
    logic            load;
    logic            fault_hit;
    logic [XLEN-1:0] fault_at;

    // output stage registers
    logic            fetch_valid_q;
    logic [31:0]     fetch_instr_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_plus4_q;
    logic            fetch_pred_q;
    logic            fault_q;
    logic [XLEN-1:0] fault_addr_q;

    function automatic logic addr_bad(input logic [XLEN-1:0] a);
        return (a[1:0] != 2'b00) || (a >= MEM_BYTES);
    endfunction

    // Program memory: no reset. Read is asynchronous, so a write landing on
    // the word being fetched in the same cycle is seen only from the next one.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_wdata;
    end

    assign instr   = mem[pc[AW+1:2]];
    assign jal_off = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                      instr[20], instr[30:21], 1'b0};

    // Next-PC selection for the instruction currently addressed by pc.
    always_comb begin
        next_pc = pc + FOUR;
        pred_nx = 1'b0;
        if (instr[6:0] == OP_JAL) begin
            next_pc = pc + jal_off;
            pred_nx = 1'b1;
        end
`ifdef FETCH_BRANCH_PREDICT_EN
        // Backward branches are usually loop back-edges: assume taken.
        else if (instr[6:0] == OP_BRANCH && instr[31]) begin
            next_pc = pc + {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            pred_nx = 1'b1;
        end
`endif
    end

    // Control FSM. A redirect wins over everything in RUN, so the fault
    // check looks at the redirect target instead of pc whenever one is taken.
    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        fault_hit = 1'b0;
        fault_at  = '0;
        case (state)
            RUN: begin
                if (fif.redirect_valid) begin
                    if (addr_bad(fif.redirect_target)) begin
                        fault_hit = 1'b1;
                        fault_at  = fif.redirect_target;
                    end
                end else if (addr_bad(pc)) begin
                    fault_hit = 1'b1;
                    fault_at  = pc;
                end else begin
                    load = !fetch_valid_q || fif.fetch_ready;
                end
                if (fault_hit) state_nx = FAULT;
            end
            FAULT: state_nx = FAULT;
            default: state_nx = FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    // PC and output stage. In FAULT nothing moves; fetch_valid was already
    // cleared on the way in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc               <= RESET_VECTOR;
            fetch_valid_q    <= 1'b0;
            fetch_instr_q    <= '0;
            fetch_pc_q       <= '0;
            fetch_pc_plus4_q <= '0;
            fetch_pred_q     <= 1'b0;
            fault_q          <= 1'b0;
            fault_addr_q     <= '0;
        end else if (state == RUN) begin
            if (fif.redirect_valid) begin
                pc            <= fif.redirect_target;
                fetch_valid_q <= 1'b0;
            end else if (load) begin
                pc               <= next_pc;
                fetch_valid_q    <= 1'b1;
                fetch_instr_q    <= instr;
                fetch_pc_q       <= pc;
                fetch_pc_plus4_q <= pc + FOUR;
                fetch_pred_q     <= pred_nx;
            end
            if (fault_hit) begin
                fault_q       <= 1'b1;
                fault_addr_q  <= fault_at;
                fetch_valid_q <= 1'b0;
            end
        end
    end

    assign fif.fetch_valid      = fetch_valid_q;
    assign fif.fetch_instr      = fetch_instr_q;
    assign fif.fetch_pc         = fetch_pc_q;
    assign fif.fetch_pc_plus4   = fetch_pc_plus4_q;
    assign fif.fetch_pred_taken = fetch_pred_q;
    assign fault                = fault_q;
    assign fault_addr           = fault_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Scoreboard bench for fetch_unit: each scenario pushes the instructions
//   decode should receive; a negedge monitor pops and compares on every
//   accepted handshake.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    localparam int XLEN = 32;
    localparam int PW   = 64;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] JAL_P16   = 32'h0100_006F;
    localparam logic [31:0] JAL_M8    = 32'hFF9F_F06F;
    localparam logic [31:0] JAL_P248  = 32'h0F80_006F;
    localparam logic [31:0] BEQ_M8    = 32'hFE00_0CE3;
    localparam logic [31:0] BEQ_P8    = 32'h0000_0463;

    logic            clk = 1'b0;
    logic            reset;
    logic            prog_we;
    logic [5:0]      prog_addr;
    logic [31:0]     prog_wdata;
    logic            fault;
    logic [XLEN-1:0] fault_addr;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN)) fif ();

    fetch_unit #(.XLEN(XLEN), .PROG_WORDS(PW), .RESET_VECTOR(32'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .fif        (fif),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pred = pred;
        sb.push_back(e);
    endtask

    // Compare every instruction decode actually takes (a redirect discards it).
    always @(negedge clk) begin
        if (!reset && fif.fetch_valid && fif.fetch_ready && !fif.redirect_valid) begin
            if (sb.size() == 0) begin
                check("extra_fetch", {63'd0, fif.fetch_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pc",        fif.fetch_pc,         mon_e.pc);
                check("pc_plus4",  fif.fetch_pc_plus4,   mon_e.pc + 32'd4);
                check("instr",     fif.fetch_instr,      mon_e.instr);
                check("pred",      fif.fetch_pred_taken, mon_e.pred);
            end
        end
    end

    task automatic wr(input int idx, input logic [31:0] d);
        prog_we    = 1'b1;
        prog_addr  = idx[5:0];
        prog_wdata = d;
        @(posedge clk); #1;
        prog_we    = 1'b0;
    endtask

    // Hold reset, clear the scoreboard and fill memory with NOPs.
    task automatic start();
        reset              = 1'b1;
        fif.fetch_ready    = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_target = '0;
        sb.delete();
        for (int i = 0; i < PW; i++) wr(i, NOP);
    endtask

    task automatic release_reset(input logic rdy);
        fif.fetch_ready = rdy;
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check(tag, sb.size(), 0);
        fif.fetch_ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;

        // Sequential NOPs, plus reset values
        start();
        check("rst_valid",   fif.fetch_valid,      0);
        check("rst_pc",      fif.fetch_pc,         0);
        check("rst_pc4",     fif.fetch_pc_plus4,   0);
        check("rst_instr",   fif.fetch_instr,      0);
        check("rst_pred",    fif.fetch_pred_taken, 0);
        check("rst_fault",   fault,                0);
        check("rst_faddr",   fault_addr,           0);
        for (int a = 0; a < 16; a += 4) push(a, NOP, 1'b0);
        release_reset(1'b1);
        @(posedge clk); #1;
        check("first_edge_valid", fif.fetch_valid, 1);
        drain("drain_nop");

        // JAL forward +16 at 0x8
        start();
        wr(2, JAL_P16);
        push(32'h0, NOP, 0); push(32'h4, NOP, 0); push(32'h8, JAL_P16, 1);
        push(32'h18, NOP, 0); push(32'h1C, NOP, 0);
        release_reset(1'b1);
        drain("drain_jal_fwd");

        // JAL backward -8 at 0x8
        start();
        wr(2, JAL_M8);
        push(32'h0, NOP, 0); push(32'h4, NOP, 0); push(32'h8, JAL_M8, 1);
        push(32'h0, NOP, 0); push(32'h4, NOP, 0);
        release_reset(1'b1);
        drain("drain_jal_bwd");

        // Stall at 0x4 for three cycles
        start();
        for (int a = 0; a < 16; a += 4) push(a, NOP, 1'b0);
        release_reset(1'b0);
        @(posedge clk); #1;
        fif.fetch_ready = 1'b1;
        @(posedge clk); #1;
        fif.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_valid", fif.fetch_valid, 1);
            check("stall_pc",    fif.fetch_pc,    32'h4);
        end
        fif.fetch_ready = 1'b1;
        drain("drain_stall");

        // Redirect to 0x20 during a stall, with fetch_ready raised together
        start();
        push(32'h20, NOP, 0); push(32'h24, NOP, 0);
        release_reset(1'b0);
        @(posedge clk); #1;
        fif.redirect_valid  = 1'b1;
        fif.redirect_target = 32'h20;
        fif.fetch_ready     = 1'b1;
        @(posedge clk); #1;
        fif.redirect_valid  = 1'b0;
        check("redir_valid0", fif.fetch_valid, 0);
        @(posedge clk); #1;
        check("redir_pc", fif.fetch_pc, 32'h20);
        drain("drain_redir");

        // Misaligned redirect target faults
        start();
        release_reset(1'b0);
        @(posedge clk); #1;
        fif.redirect_valid  = 1'b1;
        fif.redirect_target = 32'h22;
        @(posedge clk); #1;
        check("mis_fault", fault,      1);
        check("mis_faddr", fault_addr, 32'h22);
        check("mis_valid", fif.fetch_valid, 0);
        fif.redirect_target = 32'h0;
        fif.fetch_ready     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("mis_stuck_valid", fif.fetch_valid, 0);
            check("mis_stuck_fault", fault, 1);
        end
        fif.redirect_valid = 1'b0;
        reset = 1'b1; #1;
        check("mis_rst_fault", fault, 0);
        check("mis_rst_faddr", fault_addr, 0);

        // JAL to 0x100: JAL itself delivered, fault on the next cycle
        start();
        wr(2, JAL_P248);
        push(32'h0, NOP, 0); push(32'h4, NOP, 0); push(32'h8, JAL_P248, 1);
        release_reset(1'b1);
        for (int i = 0; i < 20 && !fault; i++) begin
            @(posedge clk); #1;
        end
        check("range_fault", fault,      1);
        check("range_faddr", fault_addr, 32'h100);
        check("range_sb",    sb.size(),  0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("range_valid", fif.fetch_valid, 0);
        end
        reset = 1'b1; #1;
        check("range_rst_fault", fault, 0);

        // Backward BEQ at 0x10
        start();
        wr(4, BEQ_M8);
        for (int a = 0; a < 16; a += 4) push(a, NOP, 1'b0);
`ifdef FETCH_BRANCH_PREDICT_EN
        push(32'h10, BEQ_M8, 1); push(32'h8, NOP, 0);
`else
        push(32'h10, BEQ_M8, 0); push(32'h14, NOP, 0);
`endif
        release_reset(1'b1);
        drain("drain_beq_bwd");

        // Forward BEQ at 0x10 always falls through
        start();
        wr(4, BEQ_P8);
        for (int a = 0; a < 16; a += 4) push(a, NOP, 1'b0);
        push(32'h10, BEQ_P8, 0); push(32'h14, NOP, 0);
        release_reset(1'b1);
        drain("drain_beq_fwd");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
